muldiv_hilo: RTL

- Iterative multiply/divide unit that owns the architectural HI/LO register pair for the 32-bit MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles. Also handles single-cycle MTHI and MTLO writes.
- HI/LO are always visible to the datapath as outputs, which serves MFHI and MFLO reads.
- Sits beside the single-cycle ALU. The controller issues ops through a start/busy/done handshake and stalls on busy.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_hilo_if.sv | 25 ++
 rtl/muldiv_hilo.sv | 139 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   N      : operand and HI/LO width; the unit iterates N times per op
//   CNT_W  : width of the iteration counter (log2(N)+1)
//   op_t   : 3-bit op encoding driven by the controller (11x reserved)
//   state_t: sequencer states
//   neg_n / abs_n: two's-complement negate and magnitude on N-bit values
package muldiv_pkg;

    localparam int N     = 32;
    localparam int CNT_W = $clog2(N) + 1;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic logic [N-1:0] neg_n(input logic [N-1:0] x);
        return ~x + N'(1);
    endfunction

    function automatic logic [N-1:0] abs_n(input logic [N-1:0] x);
        return x[N-1] ? neg_n(x) : x;
    endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// Controller <-> multiply/divide unit connection.
//   start : op request, sampled on the rising edge
//   op    : op_t encoding (raw 3 bits so reserved codes can be carried)
//   a, b  : rs / rt operands
//   busy  : arithmetic op in flight
//   done  : one-cycle pulse after HI/LO were written by an arithmetic op
//   hi, lo: architectural HI/LO registers (MFHI/MFLO read these directly)
// Handshake: a request is taken on any rising edge where start=1 and busy=0;
// nothing is queued, so start while busy=1 is simply dropped.
interface muldiv_hilo_if;
    import muldiv_pkg::*;

    logic         start;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset, aborts any op in flight
//   bus       : slave side of muldiv_hilo_if (start/op/a/b in, busy/done/hi/lo out)
//   fsm_state : current sequencer state
// An accepted op spends N cycles in RUN (one shift-add or shift-subtract per
// edge) and one cycle in FINISH, where signs are restored and HI/LO written.
module muldiv_hilo
    import muldiv_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    muldiv_hilo_if.slave bus,
    output state_t       fsm_state
);

    localparam int W2 = 2 * N;

    state_t           state, state_next;
    logic [W2-1:0]    acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [N-1:0]     dvsr;      // mul: multiplicand; div: divisor (both as magnitudes)
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_res;   // negate product / quotient at FINISH
    logic             neg_rem;   // negate remainder at FINISH
    logic             div_zero;
    logic             done_q;
    logic [N-1:0]     hi_q, lo_q;

    logic             accept;
    logic             last_iter;
    logic             signed_op;
    logic [N-1:0]     a_mag, b_mag;
    logic [N:0]       mul_sum, div_tmp, div_diff;
    logic [W2-1:0]    acc_step;
    logic [W2-1:0]    prod;
    logic [N-1:0]     quo, rem;

    assign accept    = (state == IDLE) && bus.start && (bus.op[2] == 1'b0);
    assign last_iter = (cnt == CNT_W'(N - 1));
    assign signed_op = ~bus.op[0];
    assign a_mag     = signed_op ? abs_n(bus.a) : bus.a;
    assign b_mag     = signed_op ? abs_n(bus.b) : bus.b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_iter) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One iteration. Multiply adds the multiplicand when the current
    // multiplier bit (acc[0]) is set, then shifts right with the carry.
    // Divide shifts the next dividend bit into the remainder and keeps the
    // subtraction only when it does not go negative (bit N of the diff).
    always_comb begin
        mul_sum  = {1'b0, acc[W2-1:N]} + {1'b0, (acc[0] ? dvsr : {N{1'b0}})};
        div_tmp  = {acc[W2-1:N], acc[N-1]};
        div_diff = div_tmp - {1'b0, dvsr};
        if (is_div) begin
            if (!div_diff[N]) acc_step = {div_diff[N-1:0], acc[N-2:0], 1'b1};
            else              acc_step = {div_tmp[N-1:0], acc[N-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[N-1:1]};
        end
    end

    // Sign restoration. The remainder path also covers divide by zero: the
    // remainder ends up as |a| and neg_rem turns it back into a.
    always_comb begin
        prod = neg_res ? (~acc + W2'(1)) : acc;
        quo  = div_zero ? {N{1'b1}} : (neg_res ? neg_n(acc[N-1:0]) : acc[N-1:0]);
        rem  = neg_rem ? neg_n(acc[W2-1:N]) : acc[W2-1:N];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            dvsr     <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc      <= {{N{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                        dvsr     <= bus.op[1] ? b_mag : a_mag;
                        is_div   <= bus.op[1];
                        neg_res  <= signed_op & (bus.a[N-1] ^ bus.b[N-1]);
                        neg_rem  <= signed_op & bus.a[N-1];
                        div_zero <= (bus.b == '0);
                        cnt      <= '0;
                    end else if (bus.start && bus.op == OP_MTHI) begin
                        hi_q <= bus.a;
                    end else if (bus.start && bus.op == OP_MTLO) begin
                        lo_q <= bus.a;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                end
                FINISH: begin
                    if (is_div) begin
                        hi_q <= rem;
                        lo_q <= quo;
                    end else begin
                        hi_q <= prod[W2-1:N];
                        lo_q <= prod[N-1:0];
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign fsm_state = state;

endmodule
